// File: rtl/gemm_pkg.sv
// Purpose : shared GEMM definitions - drain FSM states, index-width helper, default geometry.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: drain_state_t, idx_width(), default DATA_WIDTH / matrix size / counter width.
package gemm_pkg;

  localparam int GEMM_DATA_WIDTH    = 64;
  localparam int GEMM_MATRIX_HEIGHT = 4;
  localparam int GEMM_MATRIX_WIDTH  = 4;
  localparam int GEMM_CNT_WIDTH     = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  // Index width for a dimension of n entries; a 1-entry dimension still gets a 1-bit index.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gemm_idx_counter.sv
// Purpose : row-major row/column wrap counter for walking an ROWS x COLS matrix.
// Latency : index updates on the edge after iclr/iadv; olast is a decode of the current index.
// Backpr. : none - the caller advances only when its element is consumed.
// Ports   : iclk, irst_n (async active-low); iclr zeroes the index (wins over iadv);
//           iadv steps col, wrapping into row; orow/ocol current index; olast at [ROWS-1][COLS-1].
module gemm_idx_counter
  import gemm_pkg::*;
#(
  parameter int ROWS = GEMM_MATRIX_HEIGHT,
  parameter int COLS = GEMM_MATRIX_WIDTH,
  parameter int RW   = idx_width(ROWS),
  parameter int CW   = idx_width(COLS)
) (
  input  logic          iclk,
  input  logic          irst_n,
  input  logic          iclr,
  input  logic          iadv,
  output logic [RW-1:0] orow,
  output logic [CW-1:0] ocol,
  output logic          olast
);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          w_col_wrap;
  logic          w_row_wrap;

  assign w_col_wrap = (r_col == COL_MAX);
  assign w_row_wrap = (r_row == ROW_MAX);

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (iclr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (iadv) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= w_row_wrap ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign orow  = r_row;
  assign ocol  = r_col;
  assign olast = w_col_wrap && w_row_wrap;

endmodule

// File: rtl/gemm_result_drain.sv
// Purpose : captures the GEMM result matrix on idone and streams it row-major, one element per handshake.
// Latency : element [0][0] valid the cycle after idone; back-to-back frames when idone meets the last transfer.
// Backpr. : iready low holds odata/orow/ocol/olast; an idone arriving mid-drain is dropped and flagged on ooverrun.
// Ports   : iclk, irst_n (async active-low); idone + iresult_matrix capture; iready/ovalid handshake with
//           odata/orow/ocol/olast; obusy while draining; ooverrun sticky (iclr_overrun clears, set wins);
//           oframe_count counts fully drained frames and wraps.
module gemm_result_drain
  import gemm_pkg::*;
#(
  parameter  int DATA_WIDTH    = GEMM_DATA_WIDTH,
  parameter  int MATRIX_HEIGHT = GEMM_MATRIX_HEIGHT,
  parameter  int MATRIX_WIDTH  = GEMM_MATRIX_WIDTH,
  parameter  int CNT_WIDTH     = GEMM_CNT_WIDTH,
  localparam int RW            = idx_width(MATRIX_HEIGHT),
  localparam int CW            = idx_width(MATRIX_WIDTH)
) (
  input  logic                                                   iclk,
  input  logic                                                   irst_n,
  input  logic                                                   idone,
  input  logic [MATRIX_HEIGHT-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] iresult_matrix,
  input  logic                                                   iready,
  input  logic                                                   iclr_overrun,
  output logic                                                   ovalid,
  output logic [DATA_WIDTH-1:0]                                  odata,
  output logic [RW-1:0]                                          orow,
  output logic [CW-1:0]                                          ocol,
  output logic                                                   olast,
  output logic                                                   obusy,
  output logic                                                   ooverrun,
  output logic [CNT_WIDTH-1:0]                                   oframe_count
);

  drain_state_t r_state;
  drain_state_t w_state_nxt;

  logic [MATRIX_HEIGHT-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] r_buf;
  logic                 r_overrun;
  logic [CNT_WIDTH-1:0] r_frame_count;

  logic          w_xfer;
  logic          w_last;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic          w_capture;
  logic          w_idx_clr;
  logic          w_idx_adv;
  logic          w_frame_done;
  logic          w_overrun_set;

  assign w_xfer = (r_state == DRAIN) && iready;

  gemm_idx_counter #(
    .ROWS (MATRIX_HEIGHT),
    .COLS (MATRIX_WIDTH),
    .RW   (RW),
    .CW   (CW)
  ) u_idx (
    .iclk   (iclk),
    .irst_n (irst_n),
    .iclr   (w_idx_clr),
    .iadv   (w_idx_adv),
    .orow   (w_row),
    .ocol   (w_col),
    .olast  (w_last)
  );

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    w_idx_clr     = 1'b0;
    w_idx_adv     = 1'b0;
    w_frame_done  = 1'b0;
    w_overrun_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (idone) begin
          w_capture   = 1'b1;
          w_idx_clr   = 1'b1;
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_xfer) begin
          w_idx_adv = 1'b1;
          if (w_last) begin
            w_frame_done = 1'b1;
            // A new frame landing on the final transfer is accepted with no idle bubble.
            if (idone) begin
              w_capture = 1'b1;
              w_idx_clr = 1'b1;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
        if (idone && !(w_xfer && w_last)) begin
          w_overrun_set = 1'b1;
        end
      end
    endcase
  end

  // Capture buffer has no reset: its contents are only observed while draining.
  always_ff @(posedge iclk) begin
    if (w_capture) begin
      r_buf <= iresult_matrix;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_overrun     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (iclr_overrun) begin
        r_overrun <= 1'b0;
      end
      if (w_frame_done) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
    end
  end

  assign ovalid       = (r_state == DRAIN);
  assign obusy        = (r_state == DRAIN);
  assign olast        = ovalid && w_last;
  assign odata        = ovalid ? r_buf[w_row][w_col] : '0;
  assign orow         = w_row;
  assign ocol         = w_col;
  assign ooverrun     = r_overrun;
  assign oframe_count = r_frame_count;

endmodule

// File: tb/tb_gemm_result_drain.sv
// Bench for gemm_result_drain: a 4x4x64 instance plus a degenerate 1x1 instance with a 2-bit frame counter.
// A beat-index model predicts every output each cycle; directed scenarios add hand-computed expectations.
module tb_gemm_result_drain;

  localparam int DW  = 64;
  localparam int H   = 4;
  localparam int W   = 4;
  localparam int N   = H * W;
  localparam int DW1 = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                         done0  = 1'b0;
  logic                         ready0 = 1'b0;
  logic                         clr0   = 1'b0;
  logic [H-1:0][W-1:0][DW-1:0]  mat0   = '0;
  logic                         vld0;
  logic [DW-1:0]                dat0;
  logic [1:0]                   row0;
  logic [1:0]                   col0;
  logic                         last0;
  logic                         busy0;
  logic                         ovr0;
  logic [15:0]                  cnt0;

  logic                         done1  = 1'b0;
  logic                         ready1 = 1'b0;
  logic                         clr1   = 1'b0;
  logic [0:0][0:0][DW1-1:0]     mat1   = '0;
  logic                         vld1;
  logic [DW1-1:0]               dat1;
  logic [0:0]                   row1;
  logic [0:0]                   col1;
  logic                         last1;
  logic                         busy1;
  logic                         ovr1;
  logic [1:0]                   cnt1;

  gemm_result_drain dut (
    .iclk(clk), .irst_n(rst_n), .idone(done0), .iresult_matrix(mat0), .iready(ready0),
    .iclr_overrun(clr0), .ovalid(vld0), .odata(dat0), .orow(row0), .ocol(col0),
    .olast(last0), .obusy(busy0), .ooverrun(ovr0), .oframe_count(cnt0)
  );

  gemm_result_drain #(.DATA_WIDTH(DW1), .MATRIX_HEIGHT(1), .MATRIX_WIDTH(1), .CNT_WIDTH(2)) dut1 (
    .iclk(clk), .irst_n(rst_n), .idone(done1), .iresult_matrix(mat1), .iready(ready1),
    .iclr_overrun(clr1), .ovalid(vld1), .odata(dat1), .orow(row1), .ocol(col1),
    .olast(last1), .obusy(busy1), .ooverrun(ovr1), .oframe_count(cnt1)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per instance, whether a frame is pending, which beat is being offered,
  // the captured frame flattened row-major, completed-frame total and the sticky overrun flag.
  bit          m_vld [2];
  int          m_idx [2];
  int          m_cnt [2];
  bit          m_ovr [2];
  logic [63:0] m_frm [2][N];
  logic [63:0] src   [2][N];

  task automatic model_step(input int k, input int n, input bit done, input bit rdy, input bit clr);
    bit last_xfer;
    last_xfer = m_vld[k] && rdy && (m_idx[k] == n - 1);
    if (m_vld[k] && done && !last_xfer) m_ovr[k] = 1'b1;
    else if (clr)                       m_ovr[k] = 1'b0;
    if (!m_vld[k]) begin
      if (done) begin
        for (int i = 0; i < n; i++) m_frm[k][i] = src[k][i];
        m_idx[k] = 0;
        m_vld[k] = 1'b1;
      end
    end else if (rdy) begin
      if (m_idx[k] == n - 1) begin
        m_cnt[k]++;
        m_idx[k] = 0;
        if (done) begin
          for (int i = 0; i < n; i++) m_frm[k][i] = src[k][i];
        end else begin
          m_vld[k] = 1'b0;
        end
      end else begin
        m_idx[k]++;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_vld[k] = 1'b0;
        m_idx[k] = 0;
        m_cnt[k] = 0;
        m_ovr[k] = 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) src[0][i] = mat0[i / W][i % W];
      src[1][0] = 64'(mat1[0][0]);
      model_step(0, N, done0, ready0, clr0);
      model_step(1, 1, done1, ready1, clr1);
    end
  end

  logic [63:0] log_dat [$];
  bit          log_last[$];

  // Compare process: every output of both instances against the model, away from the active edge.
  always @(negedge clk) begin
    chk("vld0",  64'(vld0),  64'(m_vld[0]));
    chk("busy0", 64'(busy0), 64'(m_vld[0]));
    chk("last0", 64'(last0), 64'(m_vld[0] && m_idx[0] == N - 1));
    chk("dat0",  dat0,       m_vld[0] ? m_frm[0][m_idx[0]] : 64'd0);
    chk("row0",  64'(row0),  64'(m_idx[0] / W));
    chk("col0",  64'(col0),  64'(m_idx[0] % W));
    chk("ovr0",  64'(ovr0),  64'(m_ovr[0]));
    chk("cnt0",  64'(cnt0),  64'(m_cnt[0] & 32'hFFFF));
    chk("vld1",  64'(vld1),  64'(m_vld[1]));
    chk("busy1", 64'(busy1), 64'(m_vld[1]));
    chk("last1", 64'(last1), 64'(m_vld[1]));
    chk("dat1",  64'(dat1),  m_vld[1] ? (m_frm[1][0] & 64'hFF) : 64'd0);
    chk("row1",  64'(row1),  64'd0);
    chk("col1",  64'(col1),  64'd0);
    chk("ovr1",  64'(ovr1),  64'(m_ovr[1]));
    chk("cnt1",  64'(cnt1),  64'(m_cnt[1] & 3));
    if (rst_n && vld0 && ready0) begin
      log_dat.push_back(dat0);
      log_last.push_back(last0);
    end
  end

  logic [63:0] exp_frm [N];
  int          exp_wrap [5] = '{1, 2, 3, 0, 1};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rand0();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        mat0[r][c] = {$urandom, $urandom};
  endtask

  task automatic snap0();
    for (int i = 0; i < N; i++) exp_frm[i] = mat0[i / W][i % W];
  endtask

  task automatic clear_log();
    log_dat.delete();
    log_last.delete();
  endtask

  task automatic run_to_idle(input string name);
    for (int n = 0; n < 200 && vld0; n++) cyc();
    chk({name, "_drain_timeout"}, 64'(vld0), 64'd0);
  endtask

  task automatic check_log(input string name);
    chk({name, "_beats"}, 64'(log_dat.size()), 64'(N));
    for (int i = 0; i < N && i < log_dat.size(); i++) begin
      chk({name, "_dat"},  log_dat[i], exp_frm[i]);
      chk({name, "_last"}, 64'(log_last[i]), 64'(i == N - 1));
    end
  endtask

  task automatic start0();
    done0 = 1'b1;
    cyc();
    done0 = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_vld",  64'(vld0),  64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_last", 64'(last0), 64'd0);
    chk("rst_dat",  dat0,       64'd0);
    chk("rst_row",  64'(row0),  64'd0);
    chk("rst_col",  64'(col0),  64'd0);
    chk("rst_ovr",  64'(ovr0),  64'd0);
    chk("rst_cnt",  64'(cnt0),  64'd0);
    rst_n = 1'b1;
    cyc();

    // Basic drain: element value 16*r+c, ready held high.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        mat0[r][c] = 64'(16 * r + c);
    for (int i = 0; i < N; i++) exp_frm[i] = 64'(16 * (i / 4) + (i % 4));
    ready0 = 1'b1;
    clear_log();
    start0();
    fill_rand0();  // buffer must be independent of the live input
    chk("basic_latency", 64'(vld0), 64'd1);
    chk("basic_first",   dat0,      64'd0);
    run_to_idle("basic");
    check_log("basic");
    chk("basic_cnt",  64'(cnt0),  64'd1);
    chk("basic_busy", 64'(busy0), 64'd0);

    // Backpressure: ready pattern 1,0,0,1,0,0,...
    fill_rand0();
    snap0();
    clear_log();
    start0();
    fill_rand0();
    for (int i = 0; i < 200 && vld0; i++) begin
      ready0 = (i % 3 == 0);
      cyc();
    end
    chk("bp_timeout", 64'(vld0), 64'd0);
    check_log("bp");
    chk("bp_cnt", 64'(cnt0), 64'd2);

    // Back-to-back: new idone coincides with the olast transfer.
    ready0 = 1'b1;
    fill_rand0();
    snap0();
    clear_log();
    start0();
    repeat (15) cyc();
    chk("b2b_last_offered", 64'(last0), 64'd1);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        mat0[r][c] = 64'hAA;
    start0();
    chk("b2b_vld", 64'(vld0), 64'd1);
    chk("b2b_dat", dat0,      64'hAA);
    chk("b2b_row", 64'(row0), 64'd0);
    chk("b2b_col", 64'(col0), 64'd0);
    chk("b2b_cnt", 64'(cnt0), 64'd3);
    check_log("b2b_first");
    clear_log();
    for (int i = 0; i < N; i++) exp_frm[i] = 64'hAA;
    run_to_idle("b2b");
    check_log("b2b_second");
    chk("b2b_cnt_end", 64'(cnt0), 64'd4);

    // Overrun: idone at beat 5 is dropped, flag sticks until cleared.
    chk("ovr_pre", 64'(ovr0), 64'd0);
    fill_rand0();
    snap0();
    clear_log();
    start0();
    repeat (5) cyc();
    fill_rand0();
    start0();
    chk("ovr_set", 64'(ovr0), 64'd1);
    run_to_idle("ovr");
    check_log("ovr");
    chk("ovr_sticky", 64'(ovr0), 64'd1);
    chk("ovr_cnt",    64'(cnt0), 64'd5);
    clr0 = 1'b1;
    cyc();
    clr0 = 1'b0;
    chk("ovr_clear", 64'(ovr0), 64'd0);
    fill_rand0();
    start0();
    repeat (3) cyc();
    done0 = 1'b1;
    clr0  = 1'b1;
    cyc();
    done0 = 1'b0;
    clr0  = 1'b0;
    chk("ovr_set_wins", 64'(ovr0), 64'd1);
    run_to_idle("ovr2");
    clr0 = 1'b1;
    cyc();
    clr0 = 1'b0;
    chk("ovr_clear2", 64'(ovr0), 64'd0);

    // Asynchronous reset mid-drain at beat 7.
    fill_rand0();
    start0();
    repeat (7) cyc();
    chk("mid_vld_before", 64'(vld0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_vld",  64'(vld0),  64'd0);
    chk("mid_busy", 64'(busy0), 64'd0);
    chk("mid_last", 64'(last0), 64'd0);
    chk("mid_cnt",  64'(cnt0),  64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    fill_rand0();
    snap0();
    clear_log();
    start0();
    chk("mid_restart_dat", dat0,      exp_frm[0]);
    chk("mid_restart_row", 64'(row0), 64'd0);
    chk("mid_restart_col", 64'(col0), 64'd0);
    run_to_idle("mid");
    check_log("mid");
    chk("mid_cnt_end", 64'(cnt0), 64'd1);

    // 1x1 instance: every beat is last, 2-bit frame counter wraps.
    ready1 = 1'b1;
    for (int f = 0; f < 5; f++) begin
      logic [DW1-1:0] v;
      v = DW1'($urandom);
      mat1[0][0] = v;
      done1 = 1'b1;
      cyc();
      done1 = 1'b0;
      chk("deg_vld",  64'(vld1),  64'd1);
      chk("deg_last", 64'(last1), 64'd1);
      chk("deg_dat",  64'(dat1),  64'(v));
      cyc();
      chk("wrap_cnt", 64'(cnt1), 64'(exp_wrap[f]));
      chk("deg_idle", 64'(vld1), 64'd0);
    end

    // Random traffic on both instances, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      ready0 = ($urandom_range(0, 3) != 0);
      done0  = ($urandom_range(0, 19) == 0);
      clr0   = ($urandom_range(0, 15) == 0);
      if (done0) fill_rand0();
      ready1 = ($urandom_range(0, 2) != 0);
      done1  = ($urandom_range(0, 3) == 0);
      clr1   = ($urandom_range(0, 7) == 0);
      mat1[0][0] = DW1'($urandom);
      cyc();
    end
    done0  = 1'b0;
    clr0   = 1'b0;
    ready0 = 1'b1;
    done1  = 1'b0;
    clr1   = 1'b0;
    ready1 = 1'b1;
    run_to_idle("rand");
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks failed", n_fail, n_vec);
    $fatal(1, "watchdog");
  end

endmodule
